arm_hazard_controller: RTL

//  Hazard/forwarding controller for the 5-stage pipeline (F,D,E,M,W).
//  - Drives the Execute-stage 4x1 operand-mux selects for forwarding.
//  - Generates the stall/flush controls for the F/D/E pipeline registers.
//  - Sequences R15 (non-branch PC write) drains with a registered FSM.
//  - Keeps saturating stall and flush event counters for debug.
//

---
 rtl/arm_hazard_controller.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/arm_hazard_controller.sv
// Hazard and forwarding control for the F/D/E/M/W pipeline.
// Forward selects, stall/flush decode, R15-write drain FSM, debug counters.
module arm_hazard_controller #(
  parameter int CntWidth = 16,
  parameter int RegAddrW = 4
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic [RegAddrW-1:0] i_RA1_D,
  input  logic [RegAddrW-1:0] i_RA2_D,
  input  logic [RegAddrW-1:0] i_RA1_E,
  input  logic [RegAddrW-1:0] i_RA2_E,
  input  logic [RegAddrW-1:0] i_WA3_E,
  input  logic [RegAddrW-1:0] i_WA3_M,
  input  logic [RegAddrW-1:0] i_WA3_W,
  input  logic                i_RegWrite_E,
  input  logic                i_RegWrite_M,
  input  logic                i_RegWrite_W,
  input  logic                i_MemToReg_E,
  input  logic                i_BranchTaken_E,
  input  logic                i_PCWrite_D,
  output logic [1:0]          o_ForwardA_E,
  output logic [1:0]          o_ForwardB_E,
  output logic                o_StallF,
  output logic                o_StallD,
  output logic                o_FlushD,
  output logic                o_FlushE,
  output logic                o_PCFromResult,
  output logic [CntWidth-1:0] o_StallCount,
  output logic [CntWidth-1:0] o_FlushCount
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t              state;
  logic [1:0]          cnt;
  logic [CntWidth-1:0] stall_cnt;
  logic [CntWidth-1:0] flush_cnt;

  logic lduse;
  logic br_kill;
  logic ld_stall;
  logic pc_acc;

  // A load always writes its destination, so E write-enable is not needed.
  logic unused_regwrite_e;
  assign unused_regwrite_e = i_RegWrite_E;

  function automatic logic [1:0] fwd_sel(
    input logic [RegAddrW-1:0] ra
  );
    logic [1:0] s;
    s = 2'b00;
    if (ra != '1) begin
      if (i_RegWrite_M && ra == i_WA3_M)
        s = 2'b10;
      else if (i_RegWrite_W && ra == i_WA3_W)
        s = 2'b01;
    end
    return s;
  endfunction

  assign lduse = i_MemToReg_E &
                 ((i_RA1_D == i_WA3_E) |
                  (i_RA2_D == i_WA3_E));

  always_comb begin
    br_kill  = 1'b0;
    ld_stall = 1'b0;
    pc_acc   = 1'b0;
    if (i_NRESET && state == IDLE) begin
      br_kill  = i_BranchTaken_E;
      ld_stall = ~i_BranchTaken_E & lduse;
      pc_acc   = ~i_BranchTaken_E & ~lduse & i_PCWrite_D;
    end
  end

  always_comb begin
    o_ForwardA_E   = 2'b00;
    o_ForwardB_E   = 2'b00;
    o_StallF       = 1'b0;
    o_StallD       = 1'b0;
    o_FlushD       = 1'b0;
    o_FlushE       = 1'b0;
    o_PCFromResult = 1'b0;
    if (!i_NRESET) begin
      o_FlushD = 1'b1;
      o_FlushE = 1'b1;
    end else begin
      o_ForwardA_E = fwd_sel(i_RA1_E);
      o_ForwardB_E = fwd_sel(i_RA2_E);
      if (state == IDLE) begin
        unique case (1'b1)
          br_kill: begin
            o_FlushD = 1'b1;
            o_FlushE = 1'b1;
          end
          ld_stall: begin
            o_StallF = 1'b1;
            o_StallD = 1'b1;
            o_FlushE = 1'b1;
          end
          pc_acc: begin
            o_StallF = 1'b1;
            o_FlushD = 1'b1;
          end
          default: ;
        endcase
      end else begin
        o_FlushD       = 1'b1;
        o_StallF       = (cnt != 2'd0);
        o_PCFromResult = (cnt == 2'd0);
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pc_acc) begin
            state <= DRAIN;
            cnt   <= 2'd2;
          end
        end
        DRAIN: begin
          if (cnt == 2'd0)
            state <= IDLE;
          else
            cnt <= cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
      if (ld_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (br_kill && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign o_StallCount = stall_cnt;
  assign o_FlushCount = flush_cnt;

endmodule
